// File: rtl/act_fetch_sequencer_pkg.sv
// Shared types and constants for the activation fetch sequencer.
package act_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

    localparam int unsigned FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/act_fetch_sequencer_if.sv
// SRAM read port and downstream valid/ready stream of the activation fetch sequencer.
interface act_fetch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  sram_rd_en;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // Sequencer side: drives reads and the output stream.
    modport master (
        output sram_rd_en, sram_rd_addr, out_valid, out_data, out_last,
        input  sram_rd_data, out_ready
    );

    // SRAM / downstream side.
    modport slave (
        input  sram_rd_en, sram_rd_addr, out_valid, out_data, out_last,
        output sram_rd_data, out_ready
    );
endinterface

// File: rtl/act_fetch_sequencer_skid_fifo.sv
// Small power-of-two FIFO holding returned SRAM words plus their last flag.
module fetch_skid_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Head entry and empty flag.
    always_comb begin
        head  = mem[rd_ptr];
        empty = (count == '0);
    end
endmodule

// File: rtl/act_fetch_sequencer.sv
// Walks a rows x cols activation tile row-major, issues SRAM reads under a
// two-credit limit and streams the returned words downstream.
module act_fetch_sequencer
    import act_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  num_rows,
    input  logic [DIM_WIDTH-1:0]  num_cols,
    input  logic [DIM_WIDTH-1:0]  row_stride,
    act_fetch_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done
);
    fetch_state_t          state;
    logic [DIM_WIDTH-1:0]  rows_q;
    logic [DIM_WIDTH-1:0]  cols_q;
    logic [DIM_WIDTH-1:0]  stride_q;
    logic [DIM_WIDTH-1:0]  row_cnt;
    logic [DIM_WIDTH-1:0]  col_cnt;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  infl_q;
    logic                  infl_last_q;
    logic [1:0]            buf_count;
    logic                  buf_empty;
    logic [DATA_WIDTH:0]   head;
    logic                  issue;
    logic                  issue_last;
    logic                  col_wrap;
    logic                  pop;

    // Credit check, read address and stream outputs; all derived from registered state.
    always_comb begin
        issue      = (state == FETCH) && ((buf_count + {1'b0, infl_q}) < 2'd2);
        col_wrap   = (col_cnt == cols_q - DIM_WIDTH'(1));
        issue_last = (row_cnt == rows_q - DIM_WIDTH'(1)) && col_wrap;
        bus.sram_rd_en   = issue;
        bus.sram_rd_addr = row_base + ADDR_WIDTH'(col_cnt);
        bus.out_valid    = !buf_empty;
        bus.out_data     = head[DATA_WIDTH-1:0];
        bus.out_last     = head[DATA_WIDTH];
        pop              = !buf_empty && bus.out_ready;
    end

    // Control FSM, tile walk counters and the one-cycle in-flight tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rows_q      <= '0;
            cols_q      <= '0;
            stride_q    <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            row_base    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= issue && issue_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q   <= num_rows;
                        cols_q   <= num_cols;
                        stride_q <= row_stride;
                        row_base <= base_addr;
                        row_cnt  <= '0;
                        col_cnt  <= '0;
                        busy     <= 1'b1;
                        if (num_rows != '0 && num_cols != '0) begin
                            state <= FETCH;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (issue_last) begin
                            state <= DRAIN;
                        end else if (col_wrap) begin
                            col_cnt  <= '0;
                            row_cnt  <= row_cnt + DIM_WIDTH'(1);
                            row_base <= row_base + ADDR_WIDTH'(stride_q);
                        end else begin
                            col_cnt <= col_cnt + DIM_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && bus.out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    fetch_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FETCH_BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (infl_q),
        .push_data ({infl_last_q, bus.sram_rd_data}),
        .pop       (pop),
        .head      (head),
        .empty     (buf_empty),
        .count     (buf_count)
    );
endmodule

// File: tb/tb_act_fetch_sequencer.sv
// Bench for act_fetch_sequencer: tile table, hand sequences and random tiles
// checked against an address-list / credit model of the tile walk.
module tb_act_fetch_sequencer;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned NW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [NW-1:0] num_rows;
    logic [NW-1:0] num_cols;
    logic [NW-1:0] row_stride;
    logic          busy;
    logic          done;
    logic [31:0]   salt;
    int            n_vec = 0;
    int            n_err = 0;
    string         cur_tag;

    typedef struct {
        logic [AW-1:0] base;
        logic [NW-1:0] rows;
        logic [NW-1:0] cols;
        logic [NW-1:0] stride;
        int            mode;       // 0: ready high, 1: ready 1,0,1,0..., 2: random ready
        int            exp_words;
        logic [AW-1:0] exp_last;   // address of the final read
        int            exp_done;   // done offset in edges after the accepting edge, -1: unchecked
    } vec_t;

    act_fetch_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    act_fetch_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DIM_WIDTH  (NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .num_cols   (num_cols),
        .row_stride (row_stride),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // SRAM: one-cycle latency, word encodes the tile salt and the address read.
    always @(posedge clk) begin
        if (bus.sram_rd_en) bus.sram_rd_data <= {salt, 20'h0, bus.sram_rd_addr};
        else                bus.sram_rd_data <= {$urandom, $urandom};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int j);
        case (mode)
            0:       return 1'b1;
            1:       return (j % 2 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_tile(input string tag, input logic [AW-1:0] b, input logic [NW-1:0] nr,
                            input logic [NW-1:0] nc, input logic [NW-1:0] st, input int mode,
                            input int exp_words, input logic [AW-1:0] exp_last, input int exp_done,
                            input int inject_at, input int reset_after);
        logic [AW-1:0] exp_addr[$];
        logic [AW-1:0] last_rd;
        logic [DW-1:0] pd;
        logic          pv, pr, pl;
        int            n, issued, xfers, first_rd, first_val, last_xfer_j;
        bit            finished;
        cur_tag = tag;
        exp_addr = {};
        for (int r = 0; r < int'(nr); r++)
            for (int c = 0; c < int'(nc); c++)
                exp_addr.push_back(AW'(int'(b) + r * int'(st) + c));
        n = exp_addr.size();
        issued = 0; xfers = 0; first_rd = -1; first_val = -1; last_xfer_j = -1;
        last_rd = '0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; finished = 1'b0;
        salt = $urandom;

        @(negedge clk);
        start = 1'b1; base_addr = b; num_rows = nr; num_cols = nc; row_stride = st;
        bus.out_ready = 1'b0;

        for (int j = 0; j < 400 && !finished; j++) begin
            @(negedge clk);
            if (reset_after > 0 && xfers == reset_after) begin
                reset = 1'b1; start = 1'b0;
                @(negedge clk);
                chk("rst_rd_en", bus.sram_rd_en, 0);
                chk("rst_valid", bus.out_valid, 0);
                chk("rst_data", bus.out_data, 0);
                chk("rst_last", bus.out_last, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                reset = 1'b0;
                @(negedge clk);
                chk("post_rst_valid", bus.out_valid, 0);
                chk("post_rst_rd_en", bus.sram_rd_en, 0);
                chk("post_rst_done", done, 0);
                return;
            end
            if (j == inject_at) begin
                start = 1'b1; base_addr = b + 12'h123; num_rows = nr + 8'd1;
                num_cols = nc + 8'd2; row_stride = st + 8'd3;
            end else begin
                start = 1'b0; base_addr = AW'($urandom); num_rows = NW'($urandom);
                num_cols = NW'($urandom); row_stride = NW'($urandom);
            end
            bus.out_ready = ready_for(mode, j);

            if (bus.sram_rd_en) begin
                chk("credit_free", ((issued - xfers) < 2) ? 1 : 0, 1);
                if (issued < n) chk("rd_addr", 64'(bus.sram_rd_addr), 64'(exp_addr[issued]));
                else            chk("read_count", issued + 1, n);
                if (first_rd < 0) first_rd = j;
                last_rd = bus.sram_rd_addr;
                issued++;
            end
            if (pv && !pr) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, pd);
                chk("stall_last", bus.out_last, pl);
            end
            if (bus.out_valid) begin
                if (first_val < 0) first_val = j;
                if (xfers < n) begin
                    chk("out_data", bus.out_data, {salt, 20'h0, exp_addr[xfers]});
                    chk("out_last", bus.out_last, (xfers == n - 1) ? 1 : 0);
                end else begin
                    chk("word_count", xfers + 1, n);
                end
            end
            if (done) begin
                chk("done_busy", busy, 1);
                chk("done_words", xfers, n);
                if (n > 0) chk("done_after_last", last_xfer_j, j - 1);
                if (exp_done >= 0) chk("done_ofs", j, exp_done);
                finished = 1'b1;
            end else begin
                chk("busy", busy, 1);
            end
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                xfers++;
                last_xfer_j = j;
            end
        end

        chk("done_seen", finished, 1);
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", bus.out_valid, 0);
        chk("reads_issued", issued, exp_words);
        if (n > 0) begin
            chk("last_rd_addr", last_rd, exp_last);
            chk("first_rd_ofs", first_rd, 0);
            chk("first_valid_ofs", first_val, 2);
        end else begin
            chk("no_valid", first_val, -1);
        end
    endtask

    initial begin
        vec_t          vt[7];
        logic [AW-1:0] b;
        logic [NW-1:0] nr, nc, st;

        reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0;
        row_stride = '0; bus.out_ready = 1'b0; salt = '0;
        cur_tag = "reset";
        repeat (3) @(negedge clk);
        chk("rd_en", bus.sram_rd_en, 0);
        chk("valid", bus.out_valid, 0);
        chk("data", bus.out_data, 0);
        chk("last", bus.out_last, 0);
        chk("busy", busy, 0);
        chk("done", done, 0);
        reset = 1'b0;

        vt[0] = '{12'h010, 8'd2, 8'd3, 8'd8,   0, 6,  12'h01A, -1};
        vt[1] = '{12'h010, 8'd2, 8'd3, 8'd8,   1, 6,  12'h01A, -1};
        vt[2] = '{12'h020, 8'd0, 8'd5, 8'd4,   0, 0,  12'h000,  0};
        vt[3] = '{12'h020, 8'd3, 8'd0, 8'd4,   0, 0,  12'h000,  0};
        vt[4] = '{12'hFFE, 8'd1, 8'd4, 8'd1,   0, 4,  12'h001, -1};
        vt[5] = '{12'h7FF, 8'd1, 8'd1, 8'd0,   0, 1,  12'h7FF,  3};
        vt[6] = '{12'hF00, 8'd3, 8'd5, 8'd200, 2, 15, 12'h094, -1};
        for (int i = 0; i < 7; i++)
            run_tile($sformatf("vec%0d", i), vt[i].base, vt[i].rows, vt[i].cols, vt[i].stride,
                     vt[i].mode, vt[i].exp_words, vt[i].exp_last, vt[i].exp_done, -1, 0);

        // start pulsed mid-tile with different parameters
        run_tile("start_busy", 12'h200, 8'd3, 8'd3, 8'd16, 0, 9, 12'h222, -1, 1, 0);
        // reset after the third transfer, then a clean tile
        run_tile("reset_mid", 12'h100, 8'd4, 8'd4, 8'd4, 0, 16, 12'h10F, -1, -1, 3);
        run_tile("after_reset", 12'h100, 8'd4, 8'd4, 8'd4, 0, 16, 12'h10F, -1, -1, 0);

        for (int k = 0; k < 12; k++) begin
            b  = AW'($urandom);
            nr = NW'($urandom_range(0, 5));
            nc = NW'($urandom_range(1, 6));
            st = NW'($urandom);
            run_tile($sformatf("rand%0d", k), b, nr, nc, st, 2, int'(nr) * int'(nc),
                     AW'(int'(b) + (int'(nr) - 1) * int'(st) + int'(nc) - 1),
                     (nr == 0) ? 0 : -1, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
